// File: rtl/poly_acc_bank.sv
// poly_acc_bank
// Two independent coefficient banks (A and B), DEPTH x DATA_W each, with a
// small command sequencer for LOAD, ACCUM (read-modify-write add), READ
// (streamed out in ascending address order) and CLEAR.
//
// Optional feature macro: ACC_MOD_REDUCE_EN
//   undefined : ACCUM sums wrap modulo 2**DATA_W
//   defined   : ACCUM sums are reduced once modulo Q (s >= Q ? s - Q : s)
//
// Ports
//   clk        : clock, all state updates on rising edge
//   reset      : asynchronous active-high reset (bank contents are kept)
//   set        : block enable, low freezes every register and the banks
//   cmd        : 0 idle/abort, 1 LOAD, 2 ACCUM, 3 READ, 4 CLEAR
//   in_valid   : input beat valid in LOAD/ACCUM
//   addr_a/b   : per-bank write addresses
//   data_a/b   : per-bank input coefficients
//   addr_out   : address of the current READ beat
//   data_a/b_out : bank contents at addr_out
//   out_valid  : READ beat valid
//   status     : current state code (0 IDLE .. 4 CLEAR)
module poly_acc_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic [3:0]        cmd,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_a_out,
    output logic [DATA_W-1:0] data_b_out,
    output logic              out_valid,
    output logic [3:0]        status
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W:0]   Q_EXT    = (DATA_W+1)'(Q);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_ACCUM = 4'd2,
        ST_READ  = 4'd3,
        ST_CLEAR = 4'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_addr_out;
    logic [DATA_W-1:0] r_data_a_out;
    logic [DATA_W-1:0] r_data_b_out;
    logic [DATA_W-1:0] r_bank_a [DEPTH];
    logic [DATA_W-1:0] r_bank_b [DEPTH];

    logic              w_abort;
    logic              w_beat;
    logic              w_clr;
    logic              w_we;
    logic [ADDR_W-1:0] w_cnt_next;
    logic [ADDR_W-1:0] w_wr_addr_a;
    logic [ADDR_W-1:0] w_wr_addr_b;
    logic [DATA_W-1:0] w_wr_data_a;
    logic [DATA_W-1:0] w_wr_data_b;

    // Accumulate one coefficient; the sum is formed one bit wider so the
    // single conditional subtract sees the true carry.
    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W:0] s;
        s = {1'b0, acc} + {1'b0, d};
`ifdef ACC_MOD_REDUCE_EN
        if (s >= Q_EXT) begin
            s = s - Q_EXT;
        end else begin
            s = s;
        end
`else
        s[DATA_W] = s[DATA_W] & Q_EXT[0];
`endif
        return s[DATA_W-1:0];
    endfunction

    assign w_abort    = set & (cmd == 4'd0);
    assign w_beat     = set & in_valid & ~w_abort &
                        ((r_state == ST_LOAD) | (r_state == ST_ACCUM));
    assign w_clr      = set & ~w_abort & (r_state == ST_CLEAR);
    // Gating with reset guarantees no partial write when reset lands mid-operation.
    assign w_we       = ~reset & (w_beat | w_clr);
    assign w_cnt_next = r_cnt + CNT_ONE;

    assign status     = r_state;
    assign out_valid  = r_out_valid & set;
    assign addr_out   = r_addr_out;
    assign data_a_out = r_data_a_out;
    assign data_b_out = r_data_b_out;

    // Select write address/data for the shared bank write port.
    always_comb begin
        w_wr_addr_a = addr_a;
        w_wr_addr_b = addr_b;
        w_wr_data_a = data_a;
        w_wr_data_b = data_b;
        case (r_state)
            ST_ACCUM: begin
                // Banks are read combinationally, so back-to-back beats to
                // one address see the previous cycle's result.
                w_wr_data_a = acc_add(r_bank_a[addr_a], data_a);
                w_wr_data_b = acc_add(r_bank_b[addr_b], data_b);
            end
            ST_CLEAR: begin
                w_wr_addr_a = r_cnt;
                w_wr_addr_b = r_cnt;
                w_wr_data_a = {DATA_W{1'b0}};
                w_wr_data_b = {DATA_W{1'b0}};
            end
            default: begin
                w_wr_addr_a = addr_a;
                w_wr_addr_b = addr_b;
            end
        endcase
    end

    // Bank storage write port; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_bank_a[w_wr_addr_a] <= w_wr_data_a;
            r_bank_b[w_wr_addr_b] <= w_wr_data_b;
        end
    end

    // Command sequencer, beat counter and registered READ outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {ADDR_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_addr_out   <= {ADDR_W{1'b0}};
            r_data_a_out <= {DATA_W{1'b0}};
            r_data_b_out <= {DATA_W{1'b0}};
        end else if (set) begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt       <= {ADDR_W{1'b0}};
                    r_out_valid <= 1'b0;
                    case (cmd)
                        4'd1: r_state <= ST_LOAD;
                        4'd2: r_state <= ST_ACCUM;
                        4'd3: begin
                            // Beat 0 is presented in the first READ cycle.
                            r_state      <= ST_READ;
                            r_out_valid  <= 1'b1;
                            r_addr_out   <= {ADDR_W{1'b0}};
                            r_data_a_out <= r_bank_a[0];
                            r_data_b_out <= r_bank_b[0];
                        end
                        4'd4: r_state <= ST_CLEAR;
                        default: r_state <= ST_IDLE;
                    endcase
                end
                ST_LOAD, ST_ACCUM, ST_CLEAR: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= {ADDR_W{1'b0}};
                    end else if (w_beat | w_clr) begin
                        r_cnt <= w_cnt_next;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (w_abort || (r_cnt == CNT_LAST)) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= {ADDR_W{1'b0}};
                        r_out_valid <= 1'b0;
                    end else begin
                        r_cnt        <= w_cnt_next;
                        r_addr_out   <= w_cnt_next;
                        r_data_a_out <= r_bank_a[w_cnt_next];
                        r_data_b_out <= r_bank_b[w_cnt_next];
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= {ADDR_W{1'b0}};
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
